// File: rtl/adc_scan.sv
// Round-robin scanner for an MCP3008-style 10-bit SPI ADC (mode 0).
// Keeps the latest conversion of every channel on a flat result bus.
module adc_scan #(
  parameter int CLK_DIV = 4,
  parameter int NUM_CH  = 8,
  parameter int GAP_CYC = 16
) (
  input  logic                   SYS_CLK,
  input  logic                   RST,
  input  logic                   enable,
  output logic                   ADC_SCLK,
  output logic                   ADC_CS_N,
  output logic                   ADC_MOSI,
  input  logic                   ADC_MISO,
  output logic [NUM_CH*10-1:0]   adc_vals,
  output logic                   adc_valid,
  output logic [2:0]             adc_ch,
  output logic                   scan_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam int CMAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [2:0]    CH_LAST  = 3'(NUM_CH - 1);

  // Command bit presented after the SCLK fall that ends toggle 'tog' (odd toggles only).
  function automatic logic mosi_bit(input logic [5:0] tog, input logic [2:0] ch);
    logic b;
    case (tog)
      6'd1:    b = 1'b1;
      6'd3:    b = ch[2];
      6'd5:    b = ch[1];
      6'd7:    b = ch[0];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  state_t                 state_r, state_s;
  logic [CW-1:0]          cnt_r, cnt_s;
  logic [5:0]             tog_r, tog_s;
  logic [2:0]             ptr_r, ptr_s;
  logic [9:0]             shift_r, shift_s;
  logic                   sclk_r, sclk_s;
  logic                   cs_n_r, cs_n_s;
  logic                   mosi_r, mosi_s;
  logic [NUM_CH*10-1:0]   vals_r, vals_s;
  logic                   valid_r, valid_s;
  logic [2:0]             ch_r, ch_s;
  logic                   done_r, done_s;

  // Next-state and next-output logic; every output is the register of its next value.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    tog_s   = tog_r;
    ptr_s   = ptr_r;
    shift_s = shift_r;
    sclk_s  = sclk_r;
    cs_n_s  = cs_n_r;
    mosi_s  = mosi_r;
    vals_s  = vals_r;
    valid_s = 1'b0;
    ch_s    = ch_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_s = SETUP;
          cnt_s   = '0;
          cs_n_s  = 1'b0;
          mosi_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (cnt_r == DIV_LAST) begin
          state_s = SHIFT;
          cnt_s   = '0;
          tog_s   = 6'd0;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      SHIFT: begin
        if (cnt_r != DIV_LAST) begin
          cnt_s = cnt_r + CW'(1);
        end else begin
          cnt_s  = '0;
          sclk_s = ~sclk_r;
          tog_s  = tog_r + 6'd1;
          if (!sclk_r) begin
            // Rising edges k=8..17 carry B9..B0; earlier ones (incl. null bit) are dropped.
            if (tog_r >= 6'd14) begin
              shift_s = {shift_r[8:0], ADC_MISO};
            end else begin
              shift_s = shift_r;
            end
          end else begin
            mosi_s = mosi_bit(tog_r, ptr_r);
            if (tog_r == 6'd33) begin
              state_s = HOLD;
              vals_s[int'(ptr_r)*10 +: 10] = shift_r;
              valid_s = 1'b1;
              ch_s    = ptr_r;
              if (ptr_r == CH_LAST) begin
                done_s = 1'b1;
                ptr_s  = 3'd0;
              end else begin
                ptr_s = ptr_r + 3'd1;
              end
            end else begin
              state_s = SHIFT;
            end
          end
        end
      end
      HOLD: begin
        if (cnt_r == DIV_LAST) begin
          state_s = GAP;
          cnt_s   = '0;
          cs_n_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      GAP: begin
        if (cnt_r == GAP_LAST) begin
          cnt_s = '0;
          if (enable) begin
            state_s = SETUP;
            cs_n_s  = 1'b0;
            mosi_s  = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        sclk_s  = 1'b0;
        cs_n_s  = 1'b1;
        mosi_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      tog_r   <= 6'd0;
      ptr_r   <= 3'd0;
      shift_r <= 10'd0;
      sclk_r  <= 1'b0;
      cs_n_r  <= 1'b1;
      mosi_r  <= 1'b0;
      vals_r  <= '0;
      valid_r <= 1'b0;
      ch_r    <= 3'd0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      tog_r   <= tog_s;
      ptr_r   <= ptr_s;
      shift_r <= shift_s;
      sclk_r  <= sclk_s;
      cs_n_r  <= cs_n_s;
      mosi_r  <= mosi_s;
      vals_r  <= vals_s;
      valid_r <= valid_s;
      ch_r    <= ch_s;
      done_r  <= done_s;
    end
  end

  assign ADC_SCLK  = sclk_r;
  assign ADC_CS_N  = cs_n_r;
  assign ADC_MOSI  = mosi_r;
  assign adc_vals  = vals_r;
  assign adc_valid = valid_r;
  assign adc_ch    = ch_r;
  assign scan_done = done_r;

endmodule

// File: tb/tb_adc_scan.sv
// Bench for adc_scan: three instances (NUM_CH 8/3/1) each driven by an ADC model
// that decodes the command, answers with known data and feeds a scoreboard.
module tb_adc_scan;
  localparam int NI = 3;

  typedef struct {
    logic [2:0] ch;
    logic [9:0] val;
    logic       last;
  } exp_t;

  typedef struct {
    int         slot;
    logic [9:0] exp;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NI-1:0]   en  = '0;
  wire  [NI-1:0]   sclk, cs_n, mosi, valid, done;
  wire  [2:0]      ach  [NI];
  wire  [79:0]     vals [NI];
  int              n_tests = 0;
  int              n_fail  = 0;

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic bad(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [9:0] respfn(input int g, input int ch, input int f);
    if (g == 0) begin
      if (f < 8) return (ch == 3) ? 10'h2A5 : 10'h000;
      return 10'((ch * 37 + f * 91) ^ 341);
    end else if (g == 1) begin
      return 10'(ch * 100 + f * 7 + 1);
    end
    return (f % 2 == 1) ? 10'h001 : 10'h3FF;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int NC = (g == 0) ? 8 : ((g == 1) ? 3 : 1);
    wire  [NC*10-1:0] v;
    wire  [2:0]       c;
    logic             m = 1'b0;
    int   k = 0, lo = 0, hi = 0, fcnt = 0, expn = 0, vcnt = 0, dcnt = 0, nfr = 0, curch = 0;
    logic psclk = 1'b0, pcs = 1'b1, pmosi = 1'b0, gap_ok = 1'b0;
    logic [4:0]  cmd = 5'd0;
    logic [9:0]  resp = 10'd0;
    logic [79:0] mirror = '0;
    exp_t q[$];
    exp_t e;

    adc_scan #(.CLK_DIV(4), .NUM_CH(NC), .GAP_CYC(16)) dut (
      .SYS_CLK(clk), .RST(rst), .enable(en[g]),
      .ADC_SCLK(sclk[g]), .ADC_CS_N(cs_n[g]), .ADC_MOSI(mosi[g]), .ADC_MISO(m),
      .adc_vals(v), .adc_valid(valid[g]), .adc_ch(c), .scan_done(done[g])
    );
    assign vals[g] = 80'(v);
    assign ach[g]  = c;

    // ADC model, frame timing monitor and scoreboard for this instance
    always @(posedge clk) begin
      #1;
      if (rst) begin
        k = 0; lo = 0; hi = 0; fcnt = 0; expn = 0; vcnt = 0; dcnt = 0; nfr = 0; curch = 0;
        psclk = 1'b0; pcs = 1'b1; pmosi = 1'b0; gap_ok = 1'b0; m = 1'b0;
        mirror = '0;
        q.delete();
      end else begin
        if (mosi[g] !== pmosi)
          chk($sformatf("i%0d mosi_moves_only_on_fall", g),
              (psclk && !sclk[g]) || (pcs && !cs_n[g]), 1'b1);
        if (cs_n[g]) begin
          if (!pcs) begin
            chk($sformatf("i%0d cs_low_cycles", g), lo, 144);
            chk($sformatf("i%0d rising_edges", g), k, 17);
            hi = 0;
            gap_ok = 1'b1;
          end
          hi++;
          if (!en[g]) gap_ok = 1'b0;
        end else begin
          if (pcs) begin
            if (gap_ok) chk($sformatf("i%0d cs_high_cycles", g), hi, 16);
            k = 0; lo = 0; nfr++;
          end
          lo++;
          if (!psclk && sclk[g]) begin
            k++;
            if (k <= 5) cmd = {cmd[3:0], mosi[g]};
            if (k == 5) begin
              chk($sformatf("i%0d start_sgl", g), cmd[4:3], 2'b11);
              chk($sformatf("i%0d ch_order", g), cmd[2:0], expn);
              chk($sformatf("i%0d ch_in_range", g), int'(cmd[2:0]) < NC, 1'b1);
              curch = int'(cmd[2:0]);
              resp = respfn(g, curch, fcnt);
              q.push_back('{cmd[2:0], resp, curch == NC - 1});
              expn = (expn + 1) % NC;
            end
          end
          if (psclk && !sclk[g]) begin
            if (k == 6) m = fcnt[0];
            else if (k >= 7 && k <= 16) m = resp[16-k];
            else m = 1'b0;
          end
        end
        if (valid[g]) begin
          if (q.size() == 0) begin
            bad($sformatf("i%0d valid_without_frame", g));
          end else begin
            e = q.pop_front();
            mirror[int'(e.ch)*10 +: 10] = e.val;
            chk($sformatf("i%0d adc_ch", g), c, e.ch);
            chk($sformatf("i%0d scan_done", g), done[g], e.last);
            chk($sformatf("i%0d adc_vals", g), vals[g], mirror);
          end
          fcnt++;
          vcnt++;
          if (done[g]) dcnt++;
        end else if (done[g]) begin
          bad($sformatf("i%0d done_without_valid", g));
        end
        psclk = sclk[g];
        pcs   = cs_n[g];
        pmosi = mosi[g];
      end
    end
  end

  vec_t tbl[8];
  int   v0, f0;
  bit   hit;

  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = '{i, (i == 3) ? 10'h2A5 : 10'h000};

    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst i%0d cs_n", i), cs_n[i], 1'b1);
      chk($sformatf("rst i%0d sclk", i), sclk[i], 1'b0);
      chk($sformatf("rst i%0d mosi", i), mosi[i], 1'b0);
      chk($sformatf("rst i%0d vals", i), vals[i], 80'd0);
      chk($sformatf("rst i%0d valid_done", i), {valid[i], done[i]}, 2'b00);
      chk($sformatf("rst i%0d adc_ch", i), ach[i], 3'd0);
    end

    rst = 1'b0;
    en[0] = 1'b1;
    hit = 1'b0;
    for (int t = 0; t < 500 && !hit; t++) begin
      @(negedge clk);
      hit = (gi[0].k == 3);
    end
    if (!hit) bad("timeout waiting for SHIFT k=3");
    #2 rst = 1'b1;
    #1;
    chk("async rst cs_n", cs_n[0], 1'b1);
    chk("async rst sclk", sclk[0], 1'b0);
    chk("async rst vals", vals[0], 80'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    en = '1;

    hit = 1'b0;
    for (int t = 0; t < 3000 && !hit; t++) begin
      @(negedge clk);
      hit = (gi[0].dcnt >= 1);
    end
    if (!hit) bad("timeout waiting for first scan_done");
    chk("scan valid count", gi[0].vcnt, 8);
    chk("scan done count", gi[0].dcnt, 1);
    chk("scan done adc_ch", ach[0], 3'd7);
    for (int i = 0; i < 8; i++)
      chk($sformatf("scan slot%0d", tbl[i].slot), vals[0][tbl[i].slot*10 +: 10], tbl[i].exp);

    hit = 1'b0;
    for (int t = 0; t < 3000 && !hit; t++) begin
      @(negedge clk);
      hit = (gi[0].curch == 5 && gi[0].k == 10 && !cs_n[0]);
    end
    if (!hit) bad("timeout waiting for ch5 k=10");
    en[0] = 1'b0;
    v0 = gi[0].vcnt;
    hit = 1'b0;
    for (int t = 0; t < 400 && !hit; t++) begin
      @(negedge clk);
      hit = (gi[0].vcnt > v0);
    end
    if (!hit) bad("timeout waiting for ch5 completion");
    chk("disable completes ch5", ach[0], 3'd5);
    f0 = gi[0].nfr;
    repeat (120) @(negedge clk);
    chk("idle no new frame", gi[0].nfr, f0);
    chk("idle cs_n high", cs_n[0], 1'b1);
    en[0] = 1'b1;
    v0 = gi[0].vcnt;
    hit = 1'b0;
    for (int t = 0; t < 400 && !hit; t++) begin
      @(negedge clk);
      hit = (gi[0].vcnt > v0);
    end
    if (!hit) bad("timeout waiting for resumed frame");
    chk("resume at ch6", ach[0], 3'd6);

    chk("nc3 enough frames", gi[1].vcnt >= 5, 1'b1);
    chk("nc3 done per pass", gi[1].dcnt, gi[1].vcnt / 3);
    chk("nc1 enough frames", gi[2].vcnt >= 2, 1'b1);
    chk("nc1 done every frame", gi[2].dcnt, gi[2].vcnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_scan.md
Name: adc_scan

Overview:
- Scans NUM_CH single-ended channels of an external 10-bit SPI ADC (MCP3008-style command/response) in round-robin order.
- Holds the latest conversion per channel on a flat bus. The bus feeds the adc_N_in inputs of the host SPI register block.
- Runs free whenever enabled; one instance per ADC chip.

Parameters:
CLK_DIV, 4, SCLK half-period in SYS_CLK cycles (legal range 2..255)
NUM_CH, 8, channels scanned per pass, 0..NUM_CH-1 (legal range 1..8)
GAP_CYC, 16, minimum ADC_CS_N high time between frames, in SYS_CLK cycles (at least 1)

Ports:
SYS_CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
enable  in  1  level; 1 = scanning allowed
ADC_SCLK  out  1  ADC serial clock, idle low (mode 0)
ADC_CS_N  out  1  ADC chip select, active low
ADC_MOSI  out  1  command bits to ADC
ADC_MISO  in  1  conversion bits from ADC
adc_vals  out  NUM_CH*10  latest result; channel n occupies bits [10n+9:10n]
adc_valid  out  1  one-cycle pulse: adc_vals updated for channel adc_ch
adc_ch  out  3  channel of the most recently completed frame
scan_done  out  1  one-cycle pulse coincident with adc_valid for channel NUM_CH-1

Behaviour:
- Reset (async, takes effect immediately, including mid-frame) sets:
  - ADC_CS_N=1, ADC_SCLK=0, ADC_MOSI=0.
  - adc_vals=0, adc_valid=0, scan_done=0, adc_ch=0.
  - Internal channel pointer=0, state=IDLE.
- All outputs are registered. No combinational path from inputs to outputs.
- States and transitions:
  - IDLE: waits for enable=1, then enters SETUP.
  - SETUP: CS_N=0, MOSI=1 (start bit); lasts CLK_DIV cycles, then SHIFT.
  - SHIFT: 17 full SCLK periods. A half-period counter counts 0..CLK_DIV-1 and SCLK toggles at the terminal count.
  - HOLD: SCLK=0 for CLK_DIV cycles, then CS_N=1 and GAP.
  - GAP: CS_N high for GAP_CYC cycles. Then SETUP if enable=1, else IDLE.
- MOSI sequence per rising edge k (1..17):
  - k=1: 1 (start bit).
  - k=2: 1 (single-ended).
  - k=3..5: channel pointer bits [2:0], MSB first.
  - k=6..17: 0.
  - MOSI changes only on the SYS_CLK cycle where SCLK falls; bit 1 is presented from SETUP entry.
- MISO capture:
  - MISO is sampled in the SYS_CLK cycle where SCLK goes 0→1, for k=8..17 only.
  - It is shifted MSB first into a 10-bit shift register.
  - Edges k=1..7 (including the null bit) are ignored. No synchronizer.
- Frame completion, in the cycle HOLD is entered:
  - The 10-bit result is written to the pointer's slot in adc_vals; all other slots are unchanged.
  - adc_ch takes the pointer value and adc_valid pulses for 1 cycle.
  - scan_done also pulses if pointer=NUM_CH-1.
  - The pointer then advances, wrapping NUM_CH-1→0.
- Frame length is exact: SETUP CLK_DIV + SHIFT 34*CLK_DIV + HOLD CLK_DIV cycles with CS_N low. With CLK_DIV=4 that is 144 cycles, followed by GAP_CYC high.
- enable deasserted mid-frame: the frame completes normally (valid/update occurs), then GAP, then IDLE. The pointer is kept, so re-enable resumes at the next channel.
- enable reasserted during GAP: no extra delay. GAP always runs its full length.
- adc_vals holds its last values indefinitely while idle.

Test Plan:
- Reset mid-SHIFT (CLK_DIV=4, NUM_CH=8, ADC model active) -> same cycle CS_N=1, SCLK=0; adc_vals=0; after release with enable=1, first frame addresses ch0 (MOSI bits k1..5 = 1,1,0,0,0).
- ADC model returns 10'h2A5 on ch3 and 10'h000 elsewhere; run one full scan -> adc_vals[39:30]=10'h2A5, other slots 0; adc_valid pulses 8 times with adc_ch 0..7; scan_done pulses once with adc_ch=7.
- Frame timing, CLK_DIV=4, GAP_CYC=16 -> CS_N low exactly 144 cycles, high exactly 16; 17 SCLK rising edges per frame; MOSI stable across every rising edge.
- NUM_CH=3 -> channel order 0,1,2,0,1; scan_done on each ch2 frame; slots for ch3..7 do not exist; no out-of-range channel is ever issued.
- Deassert enable at SHIFT edge k=10 of ch5 -> ch5 still updates with correct value, then IDLE; re-enable after 100 cycles -> next frame is ch6.
- MISO values 10'h3FF then 10'h001 on consecutive frames of one channel (NUM_CH=1) -> slot reads 3FF then 001; null-bit toggling on MISO at k=7 does not affect the result.
